mips_data_memory: RTL and testbench

MIPS_DATA_MEMORY -- requirements
Module: mips_data_memory

---
 rtl/mips_mem_pkg.sv | 16 +
 rtl/mips_byte_ram.sv | 32 +++
 rtl/mips_data_memory.sv | 118 +++++++++++
 tb/tb_mips_data_memory.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and defaults for the MIPS data memory model.
// Imported by the byte RAM and the memory controller.
package mips_mem_pkg;

    localparam int DEF_MEM_BYTES = 4096;
    localparam int DEF_LATENCY   = 4;
    localparam int LANES         = 4;
    localparam int CNT_W         = 4;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } mem_state_e;

endpackage

// File: rtl/mips_byte_ram.sv
// Byte-wide storage with four independent lane ports.
// Reads are combinational; all lanes write together on one enable.
module mips_byte_ram
    import mips_mem_pkg::*;
#(
    parameter int MEM_BYTES = DEF_MEM_BYTES,
    localparam int AW = $clog2(MEM_BYTES)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr  [0:LANES-1],
    input  logic [7:0]    wdata [0:LANES-1],
    output logic [7:0]    rdata [0:LANES-1]
);

    logic [7:0] mem_q [0:MEM_BYTES-1];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < LANES; i++) begin
                mem_q[addr[i]] <= wdata[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            rdata[i] = mem_q[addr[i]];
        end
    end

endmodule

// File: rtl/mips_data_memory.sv
// Fixed-latency word memory for the MIPS core: IDLE/BUSY/DONE handshake
// with captured operands, wrapping byte lanes and a registered read port.
module mips_data_memory
    import mips_mem_pkg::*;
#(
    parameter int MEM_BYTES = DEF_MEM_BYTES,
    parameter int LATENCY   = DEF_LATENCY
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr,
    input  logic [7:0]  mem_data_in  [0:LANES-1],
    output logic [7:0]  mem_data_out [0:LANES-1],
    input  logic        mem_write_en,
    input  logic        mem_read_en,
    input  logic        halted,
    output logic        mem_ready
);

    localparam int AW = $clog2(MEM_BYTES);

    mem_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0] wdata_q [0:LANES-1];
    logic [7:0] wdata_d [0:LANES-1];
    logic [7:0] dout_q [0:LANES-1];
    logic [7:0] dout_d [0:LANES-1];
    logic wr_q, wr_d;
    logic ready_q, ready_d;

    logic [AW-1:0] lane_addr [0:LANES-1];
    logic [7:0] ram_rdata [0:LANES-1];
    logic ram_we;
    logic unused_addr_bits;

    assign unused_addr_bits = ^mem_addr;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        dout_d  = dout_q;
        ready_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if ((mem_read_en | mem_write_en) & ~halted) begin
                    state_d = BUSY;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    addr_d  = mem_addr[AW-1:0];
                    wdata_d = mem_data_in;
                    // Write wins when both enables are raised together.
                    wr_d    = mem_write_en;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                ready_d = 1'b1;
                if (!wr_q) begin
                    dout_d = ram_rdata;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '{default: '0};
            wr_q    <= 1'b0;
            dout_q  <= '{default: '0};
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            dout_q  <= dout_d;
            ready_q <= ready_d;
        end
    end

    // Lane addresses wrap naturally in AW bits at the top of memory.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            lane_addr[i] = addr_q + AW'(i);
        end
    end

    assign ram_we = (state_q == DONE) && wr_q && !rst;

    mips_byte_ram #(
        .MEM_BYTES(MEM_BYTES)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (lane_addr),
        .wdata(wdata_q),
        .rdata(ram_rdata)
    );

    assign mem_data_out = dout_q;
    assign mem_ready    = ready_q;

endmodule

// File: tb/tb_mips_data_memory.sv
// Self-checking bench for mips_data_memory (LATENCY=4 and LATENCY=1 builds).
module tb_mips_data_memory;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = '0;
    logic [7:0]  din  [0:3] = '{default: '0};
    logic [7:0]  dout [0:3];
    logic        wr = 1'b0;
    logic        rd = 1'b0;
    logic        halted = 1'b0;
    logic        ready;

    logic [31:0] addr1 = '0;
    logic [7:0]  din1  [0:3] = '{default: '0};
    logic [7:0]  dout1 [0:3];
    logic        wr1 = 1'b0;
    logic        rd1 = 1'b0;
    logic        halted1 = 1'b0;
    logic        ready1;

    int errors = 0;
    int checks = 0;
    logic [31:0] sb_q [$];

    always #5 clk = ~clk;

    mips_data_memory #(.MEM_BYTES(4096), .LATENCY(4)) u_dut (
        .clk(clk), .rst(rst), .mem_addr(addr),
        .mem_data_in(din), .mem_data_out(dout),
        .mem_write_en(wr), .mem_read_en(rd),
        .halted(halted), .mem_ready(ready)
    );

    mips_data_memory #(.MEM_BYTES(4096), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .mem_addr(addr1),
        .mem_data_in(din1), .mem_data_out(dout1),
        .mem_write_en(wr1), .mem_read_en(rd1),
        .halted(halted1), .mem_ready(ready1)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        bit          wr;
        bit          rd;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [10];

    function automatic logic [31:0] pk(input logic [7:0] l [0:3]);
        return {l[0], l[1], l[2], l[3]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_data(input logic [31:0] d);
        for (int i = 0; i < 4; i++) din[i] = d[31-8*i -: 8];
    endtask

    task automatic txn(input logic [31:0] a, input logic [31:0] d,
                       input bit w, input bit r, input logic [31:0] exp,
                       input bit halt_mid, input string name);
        int n;
        logic [31:0] e;
        @(negedge clk);
        addr = a;
        drive_data(d);
        wr = w;
        rd = r;
        sb_q.push_back(exp);
        @(posedge clk);
        #1;
        // Scramble inputs after accept; the captured copy must be used.
        addr = a + 32'h10;
        drive_data(~d);
        if (halt_mid) halted = 1'b1;
        n = 0;
        while (!ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        wr = 1'b0;
        rd = 1'b0;
        halted = 1'b0;
        chk({name, "_lat"}, n, 5);
        e = sb_q.pop_front();
        if (ready) chk({name, "_dout"}, pk(dout), e);
    endtask

    initial begin
        int pulses [$];
        logic seen;

        vecs[0] = '{32'h100,  32'h11223344, 1, 0, 32'h00000000};
        vecs[1] = '{32'h100,  32'h0,        0, 1, 32'h11223344};
        vecs[2] = '{32'hFFE,  32'hAABBCCDD, 1, 0, 32'h11223344};
        vecs[3] = '{32'h1FFE, 32'h0,        0, 1, 32'hAABBCCDD};
        vecs[4] = '{32'h103,  32'h01020304, 1, 0, 32'hAABBCCDD};
        vecs[5] = '{32'h102,  32'h0,        0, 1, 32'h33010203};
        vecs[6] = '{32'h20,   32'h5A5A5A5A, 1, 1, 32'h33010203};
        vecs[7] = '{32'h20,   32'h0,        0, 1, 32'h5A5A5A5A};
        vecs[8] = '{32'h40,   32'h77777777, 1, 0, 32'h5A5A5A5A};
        vecs[9] = '{32'h40,   32'h0,        0, 1, 32'h77777777};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'b0, ready}, 0);
        chk("rst_dout", pk(dout), 0);
        chk("rst_ready1", {31'b0, ready1}, 0);
        chk("rst_dout1", pk(dout1), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            txn(vecs[i].addr, vecs[i].data, vecs[i].wr, vecs[i].rd,
                vecs[i].exp, 0, $sformatf("vec%0d", i));
        end

        // Reset two cycles into a write must abort it.
        @(negedge clk);
        addr = 32'h40;
        drive_data(32'hEEEEEEEE);
        wr = 1'b1;
        @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        wr = 1'b0;
        #1;
        chk("abort_dout_in_rst", pk(dout), 0);
        seen = ready;
        repeat (4) begin
            @(posedge clk);
            #1;
            seen |= ready;
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            seen |= ready;
        end
        chk("abort_no_ready", {31'b0, seen}, 0);
        txn(32'h40, 32'h0, 0, 1, 32'h77777777, 0, "abort_old");

        // Halted blocks acceptance.
        @(negedge clk);
        halted = 1'b1;
        addr = 32'h100;
        rd = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            seen |= ready;
        end
        chk("halt_block", {31'b0, seen}, 0);
        rd = 1'b0;
        halted = 1'b0;

        // Halted raised mid-transaction does not abort it.
        txn(32'h100, 32'h0, 0, 1, 32'h11223301, 1, "halt_mid");

        // LATENCY=1 build with a held read pulses every 3 cycles.
        @(negedge clk);
        addr1 = 32'h0;
        rd1 = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            if (ready1) pulses.push_back(c);
        end
        rd1 = 1'b0;
        chk("lat1_count", pulses.size(), 10);
        if (pulses.size() > 0) chk("lat1_first", pulses[0], 2);
        for (int i = 1; i < pulses.size(); i++) begin
            chk($sformatf("lat1_gap%0d", i), pulses[i] - pulses[i-1], 3);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
